// File: rtl/speed_ramp_pwm.sv
`default_nettype none
// ============================================================================
// Module   : speed_ramp_pwm
// Brief    : SPI speed command -> ramped speed -> 15-step PWM, with optional
//            command watchdog (enable with macro SPEED_RAMP_WDT_EN).
// Revision : 1.0  initial release
// ============================================================================
module speed_ramp_pwm #(
    parameter int unsigned PWM_PRESCALE = 50,
    parameter int unsigned RAMP_DIV     = 50000,
    parameter int unsigned WDT_CYCLES   = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] spi_data_in,
    input  logic       spi_data_valid_in,
    output logic       pwm_out,
    output logic [3:0] current_speed_out,
    output logic       ramping_out,
    output logic       timeout_out
);

    localparam int unsigned c_pre_w  = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;
    localparam int unsigned c_step_w = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [c_pre_w-1:0]  c_pre_last  = c_pre_w'(PWM_PRESCALE - 1);
    localparam logic [c_step_w-1:0] c_step_last = c_step_w'(RAMP_DIV - 1);

    generate
        if (PWM_PRESCALE < 1 || PWM_PRESCALE > 1023 || RAMP_DIV < 1 ||
            RAMP_DIV > 1048576 || WDT_CYCLES < 2) begin : g_param_check
            $error("speed_ramp_pwm: parameter out of legal range");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_HOLD      = 2'd0,
        S_RAMP_UP   = 2'd1,
        S_RAMP_DOWN = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [3:0]            r_target;
    logic [3:0]            r_current;
    logic [3:0]            w_current_next;
    logic [c_step_w-1:0]   r_step_cnt;
    logic [c_pre_w-1:0]    r_pre_cnt;
    logic [3:0]            r_pwm_cnt;
    logic [3:0]            r_duty;
    logic                  r_pwm;
    logic                  w_tick;
    logic                  w_wdt_expire;

`ifdef SPEED_RAMP_WDT_EN
    logic [31:0] r_wdt_cnt;
    logic        r_timeout;

    // A strobe on the expiry cycle masks the expiry, so the command wins.
    assign w_wdt_expire = !spi_data_valid_in && (r_wdt_cnt == WDT_CYCLES - 32'd2);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wdt_cnt <= '0;
            r_timeout <= 1'b0;
        end else if (spi_data_valid_in) begin
            r_wdt_cnt <= '0;
            r_timeout <= 1'b0;
        end else if (r_wdt_cnt != WDT_CYCLES - 32'd1) begin
            r_wdt_cnt <= r_wdt_cnt + 32'd1;
            if (w_wdt_expire) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign timeout_out = r_timeout;
`else
    assign w_wdt_expire = 1'b0;
    assign timeout_out  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_target <= 4'd0;
        end else if (spi_data_valid_in) begin
            r_target <= spi_data_in;
        end else if (w_wdt_expire) begin
            r_target <= 4'd0;
        end
    end

    // Direction is re-evaluated every cycle; a step only happens when the
    // direction still agrees with the target, so current never overshoots.
    always_comb begin
        w_state_next   = r_state;
        w_current_next = r_current;
        case (r_state)
            S_HOLD: begin
                if (r_target > r_current) begin
                    w_state_next = S_RAMP_UP;
                end else if (r_target < r_current) begin
                    w_state_next = S_RAMP_DOWN;
                end
            end
            S_RAMP_UP: begin
                if (r_target < r_current) begin
                    w_state_next = S_RAMP_DOWN;
                end else if (r_target == r_current) begin
                    w_state_next = S_HOLD;
                end else if (r_step_cnt == c_step_last) begin
                    w_current_next = r_current + 4'd1;
                    if (w_current_next == r_target) begin
                        w_state_next = S_HOLD;
                    end
                end
            end
            S_RAMP_DOWN: begin
                if (r_target > r_current) begin
                    w_state_next = S_RAMP_UP;
                end else if (r_target == r_current) begin
                    w_state_next = S_HOLD;
                end else if (r_step_cnt == c_step_last) begin
                    w_current_next = r_current - 4'd1;
                    if (w_current_next == r_target) begin
                        w_state_next = S_HOLD;
                    end
                end
            end
            default: begin
                w_state_next = S_HOLD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_HOLD;
            r_current  <= 4'd0;
            r_step_cnt <= '0;
        end else begin
            r_state   <= w_state_next;
            r_current <= w_current_next;
            if (w_state_next != r_state || r_state == S_HOLD || r_step_cnt == c_step_last) begin
                r_step_cnt <= '0;
            end else begin
                r_step_cnt <= r_step_cnt + 1'b1;
            end
        end
    end

    assign w_tick = (r_pre_cnt == c_pre_last);

    // Duty is only sampled at the period boundary to avoid runt pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pre_cnt <= '0;
            r_pwm_cnt <= 4'd0;
            r_duty    <= 4'd0;
            r_pwm     <= 1'b0;
        end else begin
            r_pre_cnt <= w_tick ? '0 : r_pre_cnt + 1'b1;
            if (w_tick) begin
                if (r_pwm_cnt == 4'd14) begin
                    r_pwm_cnt <= 4'd0;
                    r_duty    <= r_current;
                end else begin
                    r_pwm_cnt <= r_pwm_cnt + 4'd1;
                end
            end
            r_pwm <= (r_pwm_cnt < r_duty);
        end
    end

    assign pwm_out           = r_pwm;
    assign current_speed_out = r_current;
    assign ramping_out       = (r_state != S_HOLD);

endmodule
`default_nettype wire

// File: tb/tb_speed_ramp_pwm.sv
`default_nettype none
// ============================================================================
// Module   : tb_speed_ramp_pwm
// Brief    : Vector-table and directed-sequence bench for speed_ramp_pwm.
// Revision : 1.0  initial release
// ============================================================================
module tb_speed_ramp_pwm;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] spi_data_in;
    logic       spi_data_valid_in;
    logic       pwm_out;
    logic [3:0] current_speed_out;
    logic       ramping_out;
    logic       timeout_out;

    int checks   = 0;
    int failures = 0;

    speed_ramp_pwm #(
        .PWM_PRESCALE (2),
        .RAMP_DIV     (4),
        .WDT_CYCLES   (200)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .spi_data_in       (spi_data_in),
        .spi_data_valid_in (spi_data_valid_in),
        .pwm_out           (pwm_out),
        .current_speed_out (current_speed_out),
        .ramping_out       (ramping_out),
        .timeout_out       (timeout_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic [3:0] data;
        logic [3:0] exp_speed;
        logic       exp_ramp;
    } vec_t;

    vec_t vecs [23];

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset             = 1'b1;
        spi_data_valid_in = 1'b0;
        spi_data_in       = 4'h0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic strobe(input logic [3:0] d);
        spi_data_in       = d;
        spi_data_valid_in = 1'b1;
        tick();
        spi_data_valid_in = 1'b0;
    endtask

    task automatic wait_speed(input string name, input logic [3:0] s, input int budget);
        int n = 0;
        while (current_speed_out != s && n < budget) begin
            tick();
            n++;
        end
        check(name, int'(current_speed_out), int'(s));
    endtask

    task automatic count_high(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (pwm_out) cnt++;
        end
    endtask

    initial begin
        int hi;
        int max_speed;

        // Ramp 0 -> 5: target latched at vec0, FSM enters RAMP_UP at vec1,
        // steps land every 4 clk from vec5; HOLD with the final step.
        vecs[0]  = '{1'b1, 4'h5, 4'd0, 1'b0};
        vecs[1]  = '{1'b0, 4'h0, 4'd0, 1'b1};  vecs[2]  = '{1'b0, 4'h0, 4'd0, 1'b1};
        vecs[3]  = '{1'b0, 4'h0, 4'd0, 1'b1};  vecs[4]  = '{1'b0, 4'h0, 4'd0, 1'b1};
        vecs[5]  = '{1'b0, 4'h0, 4'd1, 1'b1};  vecs[6]  = '{1'b0, 4'h0, 4'd1, 1'b1};
        vecs[7]  = '{1'b0, 4'h0, 4'd1, 1'b1};  vecs[8]  = '{1'b0, 4'h0, 4'd1, 1'b1};
        vecs[9]  = '{1'b0, 4'h0, 4'd2, 1'b1};  vecs[10] = '{1'b0, 4'h0, 4'd2, 1'b1};
        vecs[11] = '{1'b0, 4'h0, 4'd2, 1'b1};  vecs[12] = '{1'b0, 4'h0, 4'd2, 1'b1};
        vecs[13] = '{1'b0, 4'h0, 4'd3, 1'b1};  vecs[14] = '{1'b0, 4'h0, 4'd3, 1'b1};
        vecs[15] = '{1'b0, 4'h0, 4'd3, 1'b1};  vecs[16] = '{1'b0, 4'h0, 4'd3, 1'b1};
        vecs[17] = '{1'b0, 4'h0, 4'd4, 1'b1};  vecs[18] = '{1'b0, 4'h0, 4'd4, 1'b1};
        vecs[19] = '{1'b0, 4'h0, 4'd4, 1'b1};  vecs[20] = '{1'b0, 4'h0, 4'd4, 1'b1};
        vecs[21] = '{1'b0, 4'h0, 4'd5, 1'b0};  vecs[22] = '{1'b0, 4'h0, 4'd5, 1'b0};

        do_reset();
        check("reset_speed", int'(current_speed_out), 0);
        check("reset_ramping", int'(ramping_out), 0);
        check("reset_pwm", int'(pwm_out), 0);
        check("reset_timeout", int'(timeout_out), 0);

        for (int i = 0; i < 23; i++) begin
            spi_data_valid_in = vecs[i].valid;
            spi_data_in       = vecs[i].data;
            tick();
            check($sformatf("vec%0d_speed", i), int'(current_speed_out), int'(vecs[i].exp_speed));
            check($sformatf("vec%0d_ramping", i), int'(ramping_out), int'(vecs[i].exp_ramp));
        end

        // PWM duty at 5, 15 and 0
        repeat (60) tick();
        count_high(30, hi);
        check("pwm_duty5_high", hi, 10);
        strobe(4'hF);
        wait_speed("ramp_to_15", 4'hF, 100);
        check("ramp15_hold", int'(ramping_out), 0);
        repeat (60) tick();
        count_high(30, hi);
        check("pwm_duty15_high", hi, 30);
        strobe(4'h0);
        wait_speed("ramp_to_0", 4'h0, 100);
        repeat (60) tick();
        count_high(30, hi);
        check("pwm_duty0_high", hi, 0);

        // Reverse mid-ramp: up toward 0xA, at 3 retarget to 1
        do_reset();
        strobe(4'hA);
        wait_speed("rev_reach3", 4'd3, 40);
        strobe(4'h1);
        max_speed = int'(current_speed_out);
        check("rev_c1_speed", int'(current_speed_out), 3);
        for (int c = 2; c <= 10; c++) begin
            tick();
            if (int'(current_speed_out) > max_speed) max_speed = int'(current_speed_out);
            if (c == 2) check("rev_c2_ramping", int'(ramping_out), 1);
            if (c == 5) check("rev_c5_speed", int'(current_speed_out), 3);
            if (c == 6) check("rev_c6_speed", int'(current_speed_out), 2);
            if (c == 9) check("rev_c9_ramping", int'(ramping_out), 1);
            if (c == 10) begin
                check("rev_c10_speed", int'(current_speed_out), 1);
                check("rev_c10_ramping", int'(ramping_out), 0);
            end
        end
        check("rev_no_overshoot", max_speed, 3);

        // Reset mid-ramp with a coincident strobe
        do_reset();
        strobe(4'h9);
        wait_speed("rst_reach7", 4'd7, 60);
        reset             = 1'b1;
        spi_data_valid_in = 1'b1;
        spi_data_in       = 4'hF;
        tick();
        check("rst_mid_speed", int'(current_speed_out), 0);
        check("rst_mid_ramping", int'(ramping_out), 0);
        check("rst_mid_pwm", int'(pwm_out), 0);
        check("rst_mid_timeout", int'(timeout_out), 0);
        reset             = 1'b0;
        spi_data_valid_in = 1'b0;
        repeat (10) tick();
        check("rst_strobe_discard_speed", int'(current_speed_out), 0);
        check("rst_strobe_discard_ramping", int'(ramping_out), 0);

        // Watchdog: expiry lands 199 clk after the last strobe
        do_reset();
        strobe(4'h8);
        repeat (150) tick();
        check("wdt_early_timeout", int'(timeout_out), 0);
        check("wdt_early_speed", int'(current_speed_out), 8);
        repeat (48) tick();
        check("wdt_pre_expiry", int'(timeout_out), 0);
        tick();
`ifdef SPEED_RAMP_WDT_EN
        check("wdt_expiry", int'(timeout_out), 1);
        repeat (61) tick();
        check("wdt_timeout_held", int'(timeout_out), 1);
        check("wdt_ramped_to_0", int'(current_speed_out), 0);
`else
        check("wdt_expiry", int'(timeout_out), 0);
        repeat (61) tick();
        check("wdt_timeout_held", int'(timeout_out), 0);
        check("wdt_speed_held", int'(current_speed_out), 8);
`endif
        strobe(4'h3);
        check("wdt_clear", int'(timeout_out), 0);
        repeat (40) tick();
        check("wdt_resume_speed", int'(current_speed_out), 3);
        check("wdt_resume_ramping", int'(ramping_out), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/speed_ramp_pwm.md
SPEED_RAMP_PWM -- requirements
Module: speed_ramp_pwm

Interface
REQ-001 The block SHALL have parameter PWM_PRESCALE, default 50: clk cycles per PWM tick (legal range 1..1023).
REQ-002 The block SHALL have parameter RAMP_DIV, default 50000: clk cycles per ramp step (legal range 1..2^20).
REQ-003 The block SHALL have parameter WDT_CYCLES, default 50000000: clk cycles without a command before timeout (legal range 2..2^32-1).
REQ-004 The block SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-005 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 The block SHALL have port spi_data_in  input  4  speed command from the SPI slave (0..15).
REQ-007 The block SHALL have port spi_data_valid_in  input  1  one-clk strobe; spi_data_in is valid when high.
REQ-008 The block SHALL have port pwm_out  output  1  motor PWM; duty = duty_reg/15.
REQ-009 The block SHALL have port current_speed_out  output  4  current ramped speed.
REQ-010 The block SHALL have port ramping_out  output  1  high while in RAMP_UP or RAMP_DOWN.
REQ-011 The block SHALL have port timeout_out  output  1  high while the watchdog has expired.

Function
REQ-012 On a clk edge with spi_data_valid_in=1, target SHALL load spi_data_in; it is visible to the FSM the next cycle, with no gap between strobes required.
REQ-013 The prescaler SHALL count 0..PWM_PRESCALE-1 and assert a one-cycle tick on wrap.
REQ-014 On each tick, pwm_cnt SHALL advance 0..14 and wrap to 0, giving a PWM period of 15*PWM_PRESCALE clk.
REQ-015 duty_reg SHALL load current_speed only on the tick where pwm_cnt wraps 14->0, so duty never changes mid-period.
REQ-016 pwm_out SHALL be registered as (pwm_cnt < duty_reg): duty 0 -> constant low; duty 15 -> constant high.
REQ-017 The FSM SHALL have states HOLD, RAMP_UP and RAMP_DOWN.
REQ-018 From HOLD, the FSM SHALL go to RAMP_UP if target>current, to RAMP_DOWN if target<current, else stay in HOLD.
REQ-019 The step counter SHALL be cleared in HOLD and on every state change, count 0..RAMP_DIV-1 in RAMP states, and step on wrap.
REQ-020 On a step, current SHALL change by exactly ±1 toward target, never overshoot, and never wrap below 0 or above 15.
REQ-021 When current equals target after a step, the FSM SHALL return to HOLD the next cycle.
REQ-022 If target changes mid-ramp and reverses direction, the FSM SHALL switch state the next cycle without stepping current.
REQ-023 If target changes mid-ramp to equal current, the FSM SHALL go to HOLD the next cycle.
REQ-024 The first step after leaving HOLD SHALL occur RAMP_DIV cycles after state entry.

Reset
REQ-025 While reset=1 at a clk edge: target=0, current=0, duty_reg=0, all counters=0, FSM=HOLD, pwm_out=0, ramping_out=0, timeout_out=0.
REQ-026 Reset SHALL override any in-flight ramp or strobe, and a strobe coincident with reset SHALL be discarded.

Configuration
REQ-027 With macro SPEED_RAMP_WDT_EN defined, the watchdog counter SHALL clear on each strobe and otherwise increment, saturating.
REQ-028 With SPEED_RAMP_WDT_EN defined, on reaching WDT_CYCLES-1 the block SHALL set timeout_out=1 and force target=0 (ramp-down to stop).
REQ-029 With SPEED_RAMP_WDT_EN defined, timeout_out SHALL clear on the next strobe; a strobe coincident with expiry wins (no timeout).
REQ-030 Without SPEED_RAMP_WDT_EN, no watchdog logic SHALL exist, timeout_out SHALL be tied to 0, and target changes only by strobe.

Verification (bench uses PWM_PRESCALE=2, RAMP_DIV=4, WDT_CYCLES=200)
REQ-031 Reset, then strobe 4'h5 -> ramping_out=1; current_speed_out steps 1,2,3,4,5 every 4 clk; then HOLD, ramping_out=0.
REQ-032 At current=5 in HOLD -> pwm_out high 10 of every 30 clk after the next period boundary; strobe 0xF -> constant high after ramp; strobe 0 -> constant low.
REQ-033 Strobe 0xA during a ramp up from 0 that has reached 3, then strobe 0x1 -> next step goes to 2, no overshoot; ramp ends at 1.
REQ-034 Assert reset mid-ramp at current=7 -> next cycle all outputs 0 and FSM=HOLD; a strobe in the same cycle as reset is ignored.
REQ-035 With SPEED_RAMP_WDT_EN, strobe 0x8 then no strobe for 200 clk -> timeout_out=1, ramp down to 0; strobe 0x3 -> timeout_out=0, ramp to 3.
REQ-036 Without SPEED_RAMP_WDT_EN, repeat REQ-035 stimulus -> timeout_out stays 0 and current holds 8.
